dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then returns read data or a store acknowledgement over a second valid/ready handshake. It replaces the zero-latency data memory so the core's stall and hazard logic can be exercised against a multi-cycle memory.

## Interface
Parameters:
- `ADDR_W`, default 12: byte-address bits decoded. Storage is 2^(ADDR_W-2) 32-bit words. Upper address bits are ignored, so accesses wrap.
- `WAIT_CYCLES`, default 2: wait states between request accept and response. The legal range is 0..15.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `req_valid`, in, 1: a request is present.
- `req_ready`, out, 1: the responder can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, right-aligned.
- `req_ctrl`, in, 4: access control.
  - [1:0] size: 00 = word, 01 = half, 10 = byte, 11 = treated as word.
  - [2]: load zero-extend; when 0, loads are sign-extended.
  - [3]: reserved, ignored.
- `rsp_valid`, out, 1: a response is present.
- `rsp_ready`, in, 1: the initiator accepts the response.
- `rsp_rdata`, out, 32: load result, right-aligned and extended. It is 0 for stores.
- `rsp_err`, out, 1: misaligned access flag. See Configuration.

## Operation
- FSM with three states:
  - IDLE: `req_ready`=1.
  - ACCESS: counting wait states, `req_ready`=0.
  - RESP: `rsp_valid`=1, `req_ready`=0.
- Accept: when `req_valid && req_ready` in IDLE, latch `req_we`, `req_addr`, `req_wdata` and `req_ctrl`.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to ACCESS.
  - Request inputs are don't-care after the accept edge.
- ACCESS:
  - When the counter is nonzero, decrement it.
  - When the counter is 0, commit the access and go to RESP on the same edge.
  - A store writes only the addressed byte lanes.
  - A load registers `rsp_rdata`.
- RESP: hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1. On that edge, go to IDLE and clear `rsp_valid`.
- Byte lanes are little-endian. Word index is `addr[ADDR_W-1:2]`.
  - Byte lane = `addr[1:0]`.
  - Half lane = `addr[1]`: 0 selects bits [15:0], 1 selects bits [31:16].
- Load extension: `ctrl[2]`=0 sign-extends from bit 7 (byte) or bit 15 (half). `ctrl[2]`=1 zero-extends.
- Store data: the source is `wdata[7:0]` for a byte, `wdata[15:0]` for a half, and all 32 bits for a word. It is replicated into the selected lane.
- Only one access is in flight. `req_ready` is never high in ACCESS or RESP, so there is no back-to-back accept without passing through IDLE.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FSM=IDLE, counter=0.
- Storage contents are not cleared by reset. Words are undefined until written.
- Latency: with the accept at edge N, `rsp_valid` rises after edge N+1+`WAIT_CYCLES`. With `WAIT_CYCLES`=0, it rises after edge N+1.
- Best-case throughput is one access per `WAIT_CYCLES`+3 cycles. This is the case where `rsp_ready` is held at 1.
- A store is visible to a load accepted after the store's response handshake.
- Reset asserted mid-access:
  - An in-flight access is dropped.
  - A store is lost if reset arrives before its commit edge.
  - A store already committed (state RESP) remains in storage.
- `rsp_ready` asserted outside RESP is ignored.
- `req_valid` held high during ACCESS or RESP is not accepted.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: a misaligned access raises `rsp_err`=1 in RESP.
  - Misaligned means a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0.
  - A misaligned store does not modify storage.
  - A misaligned load returns `rsp_rdata`=0.
  - All timing is unchanged.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - Low address bits below the access size are forced to 0, giving a naturally aligned access.
  - `rsp_err` is tied to 0.

## Test plan
- Word round-trip, `WAIT_CYCLES`=2:
  - Store 0xDEADBEEF to 0x010, then load word from 0x010.
  - Required: `rsp_rdata`=0xDEADBEEF, and `rsp_valid` rises 3 edges after each accept.
- Byte/half lanes:
  - Store word 0x00000000 at 0x020, store byte 0x80 at 0x023, store half 0x1234 at 0x020.
  - Load word at 0x020: required 0x80001234.
  - Signed byte load at 0x023: required 0xFFFFFF80.
  - Unsigned byte load at 0x023: required 0x00000080.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Required: `rsp_rdata` stable and `req_ready`=0 throughout.
  - Required: IDLE one edge after `rsp_ready`=1.
- Wrap-around, `ADDR_W`=12: store 0x5A5A5A5A to 0x1004, then load from 0x0004. Required: 0x5A5A5A5A.
- Reset mid-access: accept store 0x11111111 to 0x030 (prior content 0x22222222), then assert `rst` during ACCESS.
  - Required: outputs return to their reset values.
  - Required: a subsequent load at 0x030 returns 0x22222222.
- Alignment: word store to 0x041.
  - With `DMEM_ALIGN_CHECK_EN` defined: required `rsp_err`=1, and 0x040 is unchanged.
  - With it undefined: required `rsp_err`=0, and the data lands at 0x040.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store in flight, WAIT_CYCLES wait states, valid/ready on both sides.
// Optional build macro DMEM_ALIGN_CHECK_EN: flag misaligned accesses via rsp_err instead of force-aligning them.
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e              state, state_nxt;
    logic [3:0]          cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [2:0]          ctrl_q;
    logic [31:0]         mem [DEPTH];

    logic                accept, commit, misalign;
    logic                is_byte, is_half;
    logic [ADDR_W-3:0]   word_idx;
    logic [31:0]         word_rd, load_data, wdata_rep;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [3:0]          be;
    logic                unused_bits;

    assign unused_bits = ^{req_ctrl[3], req_addr[31:ADDR_W]};

    assign accept = req_valid && (state == S_IDLE);
    assign commit = (state == S_ACCESS) && (cnt == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (req_valid) state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ctrl_q  <= 3'd0;
        end else if (accept) begin
            cnt     <= 4'(WAIT_CYCLES);
            we_q    <= req_we;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            ctrl_q  <= req_ctrl[2:0];
        end else if ((state == S_ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Size 11 falls through to word everywhere.
    assign is_byte  = (ctrl_q[1:0] == 2'b10);
    assign is_half  = (ctrl_q[1:0] == 2'b01);
    assign word_idx = addr_q[ADDR_W-1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (is_half && addr_q[0]) || (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane selection ignores address bits below the access size, which force-aligns unchecked accesses.
    assign word_rd = mem[word_idx];
    assign rd_byte = word_rd[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        if (is_byte) begin
            load_data = {{24{~ctrl_q[2] & rd_byte[7]}}, rd_byte};
            wdata_rep = {4{wdata_q[7:0]}};
            be        = 4'b0001 << addr_q[1:0];
        end else if (is_half) begin
            load_data = {{16{~ctrl_q[2] & rd_half[15]}}, rd_half};
            wdata_rep = {2{wdata_q[15:0]}};
            be        = addr_q[1] ? 4'b1100 : 4'b0011;
        end else begin
            load_data = word_rd;
            wdata_rep = wdata_q;
            be        = 4'b1111;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (we_q || misalign) ? 32'd0 : load_data;
            rsp_err   <= misalign;
        end
    end

    // NOTE: storage has no reset; contents survive rst and are undefined until written.
    always_ff @(posedge clk) begin
        if (commit && we_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_W=12, WAIT_CYCLES=2).
// Build with or without DMEM_ALIGN_CHECK_EN; the alignment test follows the macro.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_ctrl;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd;
    logic        er;
    int          lat;

    localparam logic [3:0] C_WORD  = 4'b0000;
    localparam logic [3:0] C_HALF  = 4'b0001;
    localparam logic [3:0] C_BYTE  = 4'b0010;
    localparam logic [3:0] C_UBYTE = 4'b0110;

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // One full transaction with rsp_ready held high; lat counts edges from accept to rsp_valid.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] ctrl, output logic [31:0] rdata, output logic err,
                             output int edges);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_ctrl = ctrl;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_ctrl = 4'hF;
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rsp_timeout addr=%h: rsp_valid not seen within %0d edges", addr, edges);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL handshake_idle addr=%h: rsp_valid=%b req_ready=%b, want 0/1", addr, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_values: ready/valid/err=%b%b%b rdata=%h, want 100 / 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_roundtrip();
        do_access(1'b1, 32'h010, 32'hDEADBEEF, C_WORD, rd, er, lat);
        n_checks++;
        if (lat !== 3 || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL store_latency: lat=%0d rdata=%h, want 3 / 00000000", lat, rd);
        end
        do_access(1'b0, 32'h010, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (lat !== 3 || rd !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL load_word: lat=%0d rdata=%h, want 3 / deadbeef", lat, rd);
        end
    endtask

    task automatic test_lanes();
        do_access(1'b1, 32'h020, 32'h00000000, C_WORD, rd, er, lat);
        do_access(1'b1, 32'h023, 32'hABCDEF80, C_BYTE, rd, er, lat);
        do_access(1'b1, 32'h020, 32'hFFFF1234, C_HALF, rd, er, lat);
        do_access(1'b0, 32'h020, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'h80001234) begin
            n_errors++;
            $display("FAIL lanes_word: got %h want 80001234", rd);
        end
        do_access(1'b0, 32'h023, 32'h0, C_BYTE, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFFFF80) begin
            n_errors++;
            $display("FAIL lanes_sbyte: got %h want ffffff80", rd);
        end
        do_access(1'b0, 32'h023, 32'h0, C_UBYTE, rd, er, lat);
        n_checks++;
        if (rd !== 32'h00000080) begin
            n_errors++;
            $display("FAIL lanes_ubyte: got %h want 00000080", rd);
        end
        do_access(1'b0, 32'h022, 32'h0, C_HALF, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFF8000) begin
            n_errors++;
            $display("FAIL lanes_shalf_hi: got %h want ffff8000", rd);
        end
        do_access(1'b0, 32'h020, 32'h0, 4'b0101, rd, er, lat);
        n_checks++;
        if (rd !== 32'h00001234) begin
            n_errors++;
            $display("FAIL lanes_uhalf_lo: got %h want 00001234", rd);
        end
        do_access(1'b0, 32'h020, 32'h0, 4'b1011, rd, er, lat);
        n_checks++;
        if (rd !== 32'h80001234) begin
            n_errors++;
            $display("FAIL lanes_size11_ctrl3: got %h want 80001234", rd);
        end
    endtask

    task automatic test_backpressure();
        int waited;
        do_access(1'b1, 32'h050, 32'h0BADF00D, C_WORD, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h050; req_ctrl = C_WORD; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'h12345678;
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin
                n_errors++;
                $display("FAIL backpressure_hold cyc%0d: valid=%b ready=%b rdata=%h, want 1/0/0badf00d",
                         i, rsp_valid, req_ready, rsp_rdata);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_release: valid=%b ready=%b, want 0/1", rsp_valid, req_ready);
        end
        do_access(1'b0, 32'h050, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'h0BADF00D) begin
            n_errors++;
            $display("FAIL held_req_not_accepted: got %h want 0badf00d", rd);
        end
    endtask

    task automatic test_wrap();
        do_access(1'b1, 32'h1004, 32'h5A5A5A5A, C_WORD, rd, er, lat);
        do_access(1'b0, 32'h0004, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'h5A5A5A5A) begin
            n_errors++;
            $display("FAIL wrap: got %h want 5a5a5a5a", rd);
        end
    endtask

    task automatic test_reset_mid_access();
        int waited;
        do_access(1'b1, 32'h030, 32'h22222222, C_WORD, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h030; req_wdata = 32'h11111111; req_ctrl = C_WORD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: ready/valid/err=%b%b%b rdata=%h, want 100 / 00000000",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        do_access(1'b0, 32'h030, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'h22222222) begin
            n_errors++;
            $display("FAIL reset_mid_store_lost: got %h want 22222222", rd);
        end
        // A store already in RESP has committed and must survive reset.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h034; req_wdata = 32'h33333333; req_ctrl = C_WORD;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_access(1'b0, 32'h034, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'h33333333) begin
            n_errors++;
            $display("FAIL reset_in_resp_store_kept: got %h want 33333333", rd);
        end
    endtask

    task automatic test_alignment();
        do_access(1'b1, 32'h040, 32'h00000000, C_WORD, rd, er, lat);
        do_access(1'b1, 32'h041, 32'hCAFEF00D, C_WORD, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        n_checks++;
        if (er !== 1'b1 || lat !== 3) begin
            n_errors++;
            $display("FAIL align_store_err: err=%b lat=%0d, want 1 / 3", er, lat);
        end
        do_access(1'b0, 32'h040, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'h00000000 || er !== 1'b0) begin
            n_errors++;
            $display("FAIL align_unchanged: rdata=%h err=%b, want 00000000 / 0", rd, er);
        end
        do_access(1'b1, 32'h040, 32'h77778888, C_WORD, rd, er, lat);
        do_access(1'b0, 32'h043, 32'h0, C_HALF, rd, er, lat);
        n_checks++;
        if (rd !== 32'h00000000 || er !== 1'b1) begin
            n_errors++;
            $display("FAIL align_load_half: rdata=%h err=%b, want 00000000 / 1", rd, er);
        end
`else
        n_checks++;
        if (er !== 1'b0) begin
            n_errors++;
            $display("FAIL align_store_err: err=%b want 0", er);
        end
        do_access(1'b0, 32'h040, 32'h0, C_WORD, rd, er, lat);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL align_forced: got %h want cafef00d", rd);
        end
        do_access(1'b0, 32'h043, 32'h0, C_HALF, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFFCAFE || er !== 1'b0) begin
            n_errors++;
            $display("FAIL align_load_half: rdata=%h err=%b, want ffffcafe / 0", rd, er);
        end
`endif
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_ctrl = 4'd0;
        rsp_ready = 1'b1;
        test_reset();
        test_word_roundtrip();
        test_lanes();
        test_backpressure();
        test_wrap();
        test_reset_mid_access();
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
